// File: rtl/alu_flags_pkg.sv
// Shared constants for the pipelined flag ALU: opcode encoding, flag-vector
// layout and flag-vector width. Imported by the ALU core and the pipeline top.
package alu_flags_pkg;

  // Flag vector is {CF, OF, ZF, SF, PF}; the indices below address it.
  localparam int FLAGW = 5;
  localparam int F_CF  = 4;
  localparam int F_OF  = 3;
  localparam int F_ZF  = 2;
  localparam int F_SF  = 1;
  localparam int F_PF  = 0;

  // Opcode encoding; codes 8 and above are unused.
  localparam int OP_ADD = 0;
  localparam int OP_SUB = 1;
  localparam int OP_AND = 2;
  localparam int OP_OR  = 3;
  localparam int OP_XOR = 4;
  localparam int OP_ADC = 5;
  localparam int OP_SBB = 6;
  localparam int OP_CMP = 7;

endpackage

// File: rtl/alu_flags_core.sv
// Purely combinational ALU with x86-style flags.
// Ports:
//   a, b    [WIDTH-1:0]  operands
//   opcode  [OPW-1:0]    operation (encoding in alu_flags_pkg)
//   cf_in                carry/borrow input used by ADC/SBB
//   c       [WIDTH-1:0]  result (CMP returns a unchanged)
//   flags   [FLAGW-1:0]  {CF,OF,ZF,SF,PF} of the computed value
module alu_flags_core
  import alu_flags_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OPW   = 3
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OPW-1:0]   opcode,
  input  logic             cf_in,
  output logic [WIDTH-1:0] c,
  output logic [FLAGW-1:0] flags
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH:0]   cin_ext;
  logic [WIDTH:0]   add_r;
  logic [WIDTH:0]   sub_r;
  logic [WIDTH-1:0] res;
  logic             cf;
  logic             of;

  // Only ADC/SBB consume the stored carry; plain ADD/SUB/CMP ignore it.
  always_comb begin
    cin_ext = '0;
    if (int'(opcode) == OP_ADC || int'(opcode) == OP_SBB) cin_ext[0] = cf_in;
  end

  // One extra bit captures carry-out (add) or borrow (sub) directly.
  assign add_r = {1'b0, a} + {1'b0, b} + cin_ext;
  assign sub_r = {1'b0, a} - {1'b0, b} - cin_ext;

  // NOTE: every output of this block gets a default first so no path leaves
  // a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    res = '0;
    c   = '0;
    cf  = 1'b0;
    of  = 1'b0;
    case (int'(opcode))
      OP_ADD, OP_ADC: begin
        res = add_r[MSB:0];
        c   = res;
        cf  = add_r[WIDTH];
        of  = (a[MSB] == b[MSB]) && (res[MSB] != a[MSB]);
      end
      OP_SUB, OP_SBB, OP_CMP: begin
        res = sub_r[MSB:0];
        // CMP reports subtraction flags but passes operand A through.
        c   = (int'(opcode) == OP_CMP) ? a : res;
        cf  = sub_r[WIDTH];
        of  = (a[MSB] != b[MSB]) && (res[MSB] != a[MSB]);
      end
      OP_AND: begin
        res = a & b;
        c   = res;
      end
      OP_OR: begin
        res = a | b;
        c   = res;
      end
      OP_XOR: begin
        res = a ^ b;
        c   = res;
      end
      default: begin
        res = '0;
        c   = '0;
      end
    endcase
  end

  // ZF/SF/PF come from the computed value, so CMP flags match SUB exactly.
  always_comb begin
    flags       = '0;
    flags[F_CF] = cf;
    flags[F_OF] = of;
    flags[F_ZF] = (res == '0);
    flags[F_SF] = res[MSB];
    flags[F_PF] = ~^res;
  end

endmodule

// File: rtl/alu_flags_pipe.sv
// Two-stage pipelined ALU with an architectural flag register.
// S1 registers the operands, the ALU core evaluates from S1, S2 registers
// result and flags. Valid/ready on both sides; up to two ops held under
// backpressure.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_ready          input handshake for a, b, opcode
//   a, b [WIDTH-1:0], opcode   operation
//   out_valid/out_ready        output handshake for c, flags
//   c [WIDTH-1:0], flags [4:0] result beat, flags {CF,OF,ZF,SF,PF}
//   flags_q [4:0]              flags of the most recent op to reach S2
module alu_flags_pipe
  import alu_flags_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OPW-1:0]   opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic [FLAGW-1:0] flags,
  output logic [FLAGW-1:0] flags_q
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [OPW-1:0]   s1_op;
  logic             s1_en;
  logic             s2_en;
  logic [WIDTH-1:0] alu_c;
  logic [FLAGW-1:0] alu_flags;

  // A stage may load when it is empty or its content moves on this edge.
  assign s2_en    = !out_valid || out_ready;
  assign s1_en    = !s1_valid || s2_en;
  assign in_ready = s1_en;

  // flags_q feeds the carry; it updates on the S1->S2 edge, so whatever op
  // sits in S1 always sees the carry of the op directly ahead of it.
  alu_flags_core #(
    .WIDTH (WIDTH),
    .OPW   (OPW)
  ) u_core (
    .a      (s1_a),
    .b      (s1_b),
    .opcode (s1_op),
    .cf_in  (flags_q[F_CF]),
    .c      (alu_c),
    .flags  (alu_flags)
  );

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values and the two stages shift without ordering races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
    end else if (s1_en) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a  <= a;
        s1_b  <= b;
        s1_op <= opcode;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      c         <= '0;
      flags     <= '0;
      flags_q   <= '0;
    end else if (s2_en) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        c       <= alu_c;
        flags   <= alu_flags;
        flags_q <= alu_flags;
      end
    end
  end

endmodule

// File: tb/tb_alu_flags_pipe.sv
// Scoreboard bench for alu_flags_pipe (WIDTH=8). The driver pushes the
// hand-computed result of each accepted op; the monitor compares every
// presented beat against the queue head and pops it when consumed.
module tb_alu_flags_pipe;
  import alu_flags_pkg::*;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0]     c;
    logic [FLAGW-1:0] f;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     a = '0;
  logic [W-1:0]     b = '0;
  logic [2:0]       opcode = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [W-1:0]     c;
  logic [FLAGW-1:0] flags;
  logic [FLAGW-1:0] flags_q;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  alu_flags_pipe #(.WIDTH(W), .OPW(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .opcode    (opcode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c),
    .flags     (flags),
    .flags_q   (flags_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input int op, input logic [W-1:0] ec, input logic [FLAGW-1:0] ef);
    int n;
    exp_t e;
    n        = 0;
    a        = ta;
    b        = tb;
    opcode   = 3'(op);
    in_valid = 1'b1;
    #1;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL issue_timeout: in_ready stayed 0, expected 1");
    end else begin
      e.c = ec;
      e.f = ef;
      sb.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: sampled well after the falling edge, when driver inputs settled.
  always @(negedge clk) begin
    #2;
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_beat: got c=0x%0h, expected no beat", c);
      end else begin
        check("beat_c", 32'(c), 32'(sb[0].c));
        check("beat_flags", 32'(flags), 32'(sb[0].f));
        check("flags_q", 32'(flags_q), 32'(sb[0].f));
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_flags_q", 32'(flags_q), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_c", 32'(c), 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // 1. ADD with latency check: accepted edge N, valid after edge N+1
    issue(8'h0F, 8'hF0, OP_ADD, 8'hFF, 5'b00011);
    #1;
    check("lat_n", 32'(out_valid), 32'd0);
    @(negedge clk);
    #1;
    check("lat_n1", 32'(out_valid), 32'd1);
    drain();

    // 2. SUB with borrow, ADD with signed overflow
    issue(8'h0F, 8'hF0, OP_SUB, 8'h1F, 5'b10000);
    issue(8'h7F, 8'h01, OP_ADD, 8'h80, 5'b01010);
    // Logic ops clear CF/OF
    issue(8'hF0, 8'h3C, OP_AND, 8'h30, 5'b00001);
    issue(8'h0F, 8'h30, OP_OR,  8'h3F, 5'b00001);
    issue(8'hFF, 8'h0F, OP_XOR, 8'hF0, 5'b00011);
    drain();

    // 3. Carry chaining back to back
    issue(8'hFF, 8'h01, OP_ADD, 8'h00, 5'b10101);
    issue(8'h00, 8'h00, OP_ADC, 8'h01, 5'b00000);
    issue(8'h00, 8'h01, OP_SUB, 8'hFF, 5'b10011);
    issue(8'h05, 8'h02, OP_SBB, 8'h02, 5'b00000);
    drain();

    // 4. Backpressure: two ops held, outputs stable, order kept
    out_ready = 1'b0;
    issue(8'h01, 8'h02, OP_ADD, 8'h03, 5'b00001);
    issue(8'h10, 8'h01, OP_SUB, 8'h0F, 5'b00001);
    #1;
    check("bp_in_ready", 32'(in_ready), 32'd0);
    repeat (3) @(negedge clk);
    out_ready = 1'b1;
    issue(8'hAA, 8'h55, OP_XOR, 8'hFF, 5'b00011);
    issue(8'h0F, 8'hF0, OP_AND, 8'h00, 5'b00101);
    drain();

    // 5. CMP: flags from subtraction, c passes A
    issue(8'h55, 8'hAA, OP_CMP, 8'h55, 5'b11010);
    drain();

    // 6. Reset with two ops in flight
    out_ready = 1'b0;
    issue(8'hFF, 8'h01, OP_ADD, 8'h00, 5'b10101);
    issue(8'h00, 8'h01, OP_SUB, 8'hFF, 5'b10011);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_flags_q", 32'(flags_q), 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check("post_rst_no_beat", 32'(out_valid), 32'd0);
    end

    // Pipeline still works after the reset
    issue(8'h7F, 8'h01, OP_ADD, 8'h80, 5'b01010);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
